// File: rtl/ederah_rd_arb_pkg.sv
// rtl/ederah_rd_arb_pkg.sv - shared types and width helpers for the ederah read arbiter
package ederah_rd_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  // A single requester still needs a one-bit ID so vectors never collapse to zero width.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ederah_order_fifo.sv
// rtl/ederah_order_fifo.sv - single-clock FIFO of requester IDs kept in AR issue order
module ederah_order_fifo
  import ederah_rd_arb_pkg::*;
#(
  parameter int ID_W  = 1,
  parameter int DEPTH = 16,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             data_clk,
  input  logic             data_rst_n,
  input  logic             push,
  input  logic [ID_W-1:0]  push_id,
  input  logic             pop,
  output logic [ID_W-1:0]  head_id,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = mem[rd_ptr];

  always_ff @(posedge data_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge data_clk) begin
    if (!data_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ederah_rd_arbiter.sv
// rtl/ederah_rd_arbiter.sv - round-robin AXI4 AR/R sharing between NUM_REQ read masters
// Optional counters enabled by EDERAH_RD_ARB_STATS_EN.
module ederah_rd_arbiter
  import ederah_rd_arb_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                          data_clk,
  input  logic                          data_rst_n,
  input  logic [NUM_REQ-1:0]            req_arvalid,
  output logic [NUM_REQ-1:0]            req_arready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]          req_arlen,
  output logic [NUM_REQ-1:0]            req_rvalid,
  input  logic [NUM_REQ-1:0]            req_rready,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic                          req_rlast,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic                          m_axi_rlast,
  output logic                          busy,
  output logic                          err_orphan_r
`ifdef EDERAH_RD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]         stat_bursts,
  output logic [31:0]                   stat_full_cycles
`endif
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  rr_next;
  logic [ID_W-1:0]  win_idx;
  logic             win_found;
  int               scan_idx;
  logic             load_ar;
  logic             ar_hs;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [ID_W-1:0]  head_id;
  logic [CNT_W-1:0] out_count;

  // Scan starts at rr_ptr so the requester after the last winner has top priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && req_arvalid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(scan_idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load_ar   = 1'b0;
    case (state)
      IDLE: begin
        if (win_found && !fifo_full) begin
          load_ar   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (m_axi_arready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign m_axi_arvalid = (state == ISSUE);
  assign ar_hs         = (state == ISSUE) && m_axi_arready;
  assign rr_next       = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    req_arready = '0;
    if (ar_hs) begin
      req_arready[grant] = 1'b1;
    end
  end

  always_ff @(posedge data_clk) begin
    if (!data_rst_n) begin
      state        <= IDLE;
      grant        <= '0;
      rr_ptr       <= '0;
      m_axi_araddr <= '0;
      m_axi_arlen  <= '0;
      err_orphan_r <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_ar) begin
        grant        <= win_idx;
        m_axi_araddr <= req_araddr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        m_axi_arlen  <= req_arlen[int'(win_idx)*8 +: 8];
      end
      if (ar_hs) begin
        rr_ptr <= rr_next;
      end
      if (m_axi_rvalid && fifo_empty) begin
        err_orphan_r <= 1'b1;
      end
    end
  end

  ederah_order_fifo #(
    .ID_W  (ID_W),
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_order_fifo (
    .data_clk   (data_clk),
    .data_rst_n (data_rst_n),
    .push       (ar_hs),
    .push_id    (grant),
    .pop        (fifo_pop),
    .head_id    (head_id),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count      (out_count)
  );

  // R beats belong to the oldest outstanding burst; with nothing outstanding they are refused.
  always_comb begin
    req_rvalid = '0;
    if (!fifo_empty) begin
      req_rvalid[head_id] = m_axi_rvalid;
    end
  end

  assign m_axi_rready = !fifo_empty && req_rready[head_id];
  assign req_rdata    = m_axi_rdata;
  assign req_rlast    = m_axi_rlast;
  assign fifo_pop     = m_axi_rvalid && m_axi_rready && m_axi_rlast;
  assign busy         = (state == ISSUE) || (out_count != '0);

`ifdef EDERAH_RD_ARB_STATS_EN
  always_ff @(posedge data_clk) begin
    if (!data_rst_n) begin
      stat_bursts      <= '0;
      stat_full_cycles <= '0;
    end else begin
      if (ar_hs && (stat_bursts[int'(grant)*32 +: 32] != 32'hFFFF_FFFF)) begin
        stat_bursts[int'(grant)*32 +: 32] <= stat_bursts[int'(grant)*32 +: 32] + 32'd1;
      end
      if ((state == IDLE) && (|req_arvalid) && fifo_full &&
          (stat_full_cycles != 32'hFFFF_FFFF)) begin
        stat_full_cycles <= stat_full_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ederah_rd_arbiter.sv
// tb/tb_ederah_rd_arbiter.sv - directed-vector bench for ederah_rd_arbiter
module tb_ederah_rd_arbiter;

  logic         data_clk = 1'b0;
  logic         data_rst_n;
  logic [1:0]   req_arvalid;
  logic [1:0]   req_arready;
  logic [127:0] req_araddr;
  logic [15:0]  req_arlen;
  logic [1:0]   req_rvalid;
  logic [1:0]   req_rready;
  logic [511:0] req_rdata;
  logic         req_rlast;
  logic         m_axi_arvalid;
  logic         m_axi_arready;
  logic [63:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic         m_axi_rvalid;
  logic         m_axi_rready;
  logic [511:0] m_axi_rdata;
  logic         m_axi_rlast;
  logic         busy;
  logic         err_orphan_r;
`ifdef EDERAH_RD_ARB_STATS_EN
  logic [63:0]  stat_bursts;
  logic [31:0]  stat_full_cycles;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 data_clk = ~data_clk;

  ederah_rd_arbiter dut (
    .data_clk         (data_clk),
    .data_rst_n       (data_rst_n),
    .req_arvalid      (req_arvalid),
    .req_arready      (req_arready),
    .req_araddr       (req_araddr),
    .req_arlen        (req_arlen),
    .req_rvalid       (req_rvalid),
    .req_rready       (req_rready),
    .req_rdata        (req_rdata),
    .req_rlast        (req_rlast),
    .m_axi_arvalid    (m_axi_arvalid),
    .m_axi_arready    (m_axi_arready),
    .m_axi_araddr     (m_axi_araddr),
    .m_axi_arlen      (m_axi_arlen),
    .m_axi_rvalid     (m_axi_rvalid),
    .m_axi_rready     (m_axi_rready),
    .m_axi_rdata      (m_axi_rdata),
    .m_axi_rlast      (m_axi_rlast),
    .busy             (busy),
    .err_orphan_r     (err_orphan_r)
`ifdef EDERAH_RD_ARB_STATS_EN
    ,
    .stat_bursts      (stat_bursts),
    .stat_full_cycles (stat_full_cycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge data_clk);
    #1;
  endtask

  task automatic issue_one(input int r, input logic [63:0] a, input logic [7:0] l);
    bit got;
    got = 1'b0;
    req_arvalid[r] = 1'b1;
    req_araddr[r*64 +: 64] = a;
    req_arlen[r*8 +: 8] = l;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      if (req_arready[r]) got = 1'b1;
    end
    check("ar_issue", 64'(got), 64'd1);
    if (got) begin
      check("ar_addr", m_axi_araddr, a);
      check("ar_len", 64'(m_axi_arlen), 64'(l));
    end
    tick();
    req_arvalid[r] = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last,
                           input logic [1:0] exp_v, input logic exp_rdy);
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = {8{d}};
    m_axi_rlast  = last;
    #1;
    check("r_valid", 64'(req_rvalid), 64'(exp_v));
    check("r_ready", 64'(m_axi_rready), 64'(exp_rdy));
    check("r_data", req_rdata[63:0], d);
    check("r_last", 64'(req_rlast), 64'(last));
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int       rem [2];
    int       order [12];
    int       g;
    int       seq [2];
    bit       got;

    data_rst_n    = 1'b0;
    req_arvalid   = '0;
    req_araddr    = '0;
    req_arlen     = '0;
    req_rready    = 2'b11;
    m_axi_arready = 1'b1;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rlast   = 1'b0;
    repeat (3) tick();

    check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("rst_araddr", m_axi_araddr, 64'd0);
    check("rst_arlen", 64'(m_axi_arlen), 64'd0);
    check("rst_arready", 64'(req_arready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_orphan", 64'(err_orphan_r), 64'd0);
    data_rst_n = 1'b1;
    tick();

    // Single requester, 4-beat burst
    req_arvalid[0] = 1'b1;
    req_araddr[63:0] = 64'h1000;
    req_arlen[7:0] = 8'd3;
    tick();
    check("t1_arvalid", 64'(m_axi_arvalid), 64'd1);
    check("t1_araddr", m_axi_araddr, 64'h1000);
    check("t1_arlen", 64'(m_axi_arlen), 64'd3);
    check("t1_arready", 64'(req_arready), 64'b01);
    tick();
    req_arvalid[0] = 1'b0;
    #1;
    check("t1_arready_pulse", 64'(req_arready), 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    tick();
    check("t1_no_reissue", 64'(m_axi_arvalid), 64'd0);
    for (int b = 0; b < 4; b++) begin
      send_beat(64'hA0 + 64'(b), (b == 3), 2'b01, 1'b1);
    end
    check("t1_busy_done", 64'(busy), 64'd0);

    // Both requesters continuously valid: rr_ptr is 1 after the previous grant to 0
    rem[0] = 6; rem[1] = 6; seq[0] = 0; seq[1] = 0;
    req_araddr[63:0]   = 64'h0;
    req_araddr[127:64] = 64'h10_0000;
    req_arlen = '0;
    req_arvalid = 2'b11;
    for (int i = 0; i < 12; i++) begin
      got = 1'b0;
      for (int n = 0; n < 10 && !got; n++) begin
        tick();
        if (req_arready != 2'b00) got = 1'b1;
      end
      check("t2_grant_seen", 64'(got), 64'd1);
      g = req_arready[1] ? 1 : 0;
      order[i] = g;
      check("t2_grant", 64'(req_arready), (i % 2 == 0) ? 64'b10 : 64'b01);
      check("t2_addr", m_axi_araddr, ((i % 2 == 0) ? 64'h10_0000 : 64'h0) + 64'(((i / 2)) * 64));
      tick();
      rem[g]--;
      seq[g]++;
      if (rem[g] == 0) req_arvalid[g] = 1'b0;
      else req_araddr[g*64 +: 64] = ((g == 1) ? 64'h10_0000 : 64'h0) + 64'(seq[g] * 64);
    end
    for (int i = 0; i < 12; i++) begin
      send_beat(64'h200 + 64'(i), 1'b1, (i % 2 == 0) ? 2'b10 : 2'b01, 1'b1);
    end
    check("t2_busy_done", 64'(busy), 64'd0);

    // Fill all 16 outstanding slots with no R traffic
    for (int k = 0; k < 16; k++) begin
      issue_one(0, 64'h4000 + 64'(k * 64), 8'd0);
    end
    req_arvalid[0] = 1'b1;
    req_araddr[63:0] = 64'h5000;
    repeat (4) tick();
    check("t3_blocked_17", 64'(m_axi_arvalid), 64'd0);
    check("t3_busy_full", 64'(busy), 64'd1);
    send_beat(64'h300, 1'b1, 2'b01, 1'b1);
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      if (req_arready[0]) got = 1'b1;
      else tick();
    end
    check("t3_issue_17", 64'(got), 64'd1);
    check("t3_addr_17", m_axi_araddr, 64'h5000);
    tick();
    req_araddr[63:0] = 64'h6000;
    m_axi_arready = 1'b0;
    repeat (2) tick();
    check("t3_blocked_18", 64'(m_axi_arvalid), 64'd0);
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    tick();
    check("t3_issue_18", 64'(m_axi_arvalid), 64'd1);
    m_axi_arready = 1'b1;
    m_axi_rvalid  = 1'b1;
    m_axi_rlast   = 1'b1;
    #1;
    check("t3_pushpop_ar", 64'(req_arready), 64'b01);
    check("t3_pushpop_r", 64'(m_axi_rready), 64'd1);
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    req_arvalid[0] = 1'b0;
    issue_one(0, 64'h7000, 8'd0);
    req_arvalid[0] = 1'b1;
    req_araddr[63:0] = 64'h8000;
    repeat (4) tick();
    check("t3_blocked_20", 64'(m_axi_arvalid), 64'd0);
    req_arvalid[0] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      send_beat(64'h400 + 64'(k), 1'b1, 2'b01, 1'b1);
    end
    tick();
    check("t3_busy_done", 64'(busy), 64'd0);

    // AR back-pressure: grant and payload frozen, late requester ignored
    m_axi_arready = 1'b0;
    req_arvalid[0] = 1'b1;
    req_araddr[63:0] = 64'hABC0;
    req_arlen[7:0] = 8'd2;
    tick();
    req_arvalid[1] = 1'b1;
    req_araddr[127:64] = 64'hDEF0;
    req_arlen[15:8] = 8'd0;
    for (int c = 0; c < 5; c++) begin
      check("t4_arvalid", 64'(m_axi_arvalid), 64'd1);
      check("t4_araddr", m_axi_araddr, 64'hABC0);
      check("t4_arlen", 64'(m_axi_arlen), 64'd2);
      check("t4_arready", 64'(req_arready), 64'd0);
      tick();
    end
    m_axi_arready = 1'b1;
    #1;
    check("t4_grant0", 64'(req_arready), 64'b01);
    tick();
    req_arvalid[0] = 1'b0;
    tick();
    check("t4_grant1", 64'(req_arready), 64'b10);
    check("t4_addr1", m_axi_araddr, 64'hDEF0);
    tick();
    req_arvalid[1] = 1'b0;

    // Owner stalls mid-burst, then orphan beat
    send_beat(64'h500, 1'b0, 2'b01, 1'b1);
    req_rready = 2'b10;
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = {8{64'h501}};
    #1;
    check("t5_stall_rready", 64'(m_axi_rready), 64'd0);
    check("t5_stall_rvalid", 64'(req_rvalid), 64'b01);
    tick();
    req_rready = 2'b11;
    send_beat(64'h501, 1'b0, 2'b01, 1'b1);
    send_beat(64'h502, 1'b1, 2'b01, 1'b1);
    send_beat(64'h503, 1'b1, 2'b10, 1'b1);
    check("t5_busy_done", 64'(busy), 64'd0);
    check("t5_orphan_clear", 64'(err_orphan_r), 64'd0);
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    #1;
    check("t5_orphan_rready", 64'(m_axi_rready), 64'd0);
    check("t5_orphan_rvalid", 64'(req_rvalid), 64'd0);
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    check("t5_orphan_set", 64'(err_orphan_r), 64'd1);
    repeat (3) tick();
    check("t5_orphan_sticky", 64'(err_orphan_r), 64'd1);
    data_rst_n = 1'b0;
    tick();
    check("t5_orphan_reset", 64'(err_orphan_r), 64'd0);
    data_rst_n = 1'b1;
    tick();

`ifdef EDERAH_RD_ARB_STATS_EN
    check("st_full_rst", 64'(stat_full_cycles), 64'd0);
    for (int k = 0; k < 3; k++) begin
      issue_one(1, 64'h9000 + 64'(k * 64), 8'd0);
    end
    check("st_bursts1", 64'(stat_bursts[63:32]), 64'd3);
    check("st_bursts0", 64'(stat_bursts[31:0]), 64'd0);
    for (int k = 0; k < 3; k++) begin
      send_beat(64'h600 + 64'(k), 1'b1, 2'b10, 1'b1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
